// File: rtl/controle_elevador.sv
`default_nettype none
// ============================================================================
//  Module      : controle_elevador
//  Description : SCAN sequencing controller for a three-floor elevator.
//                Latches call-line rising edges as pending requests, moves
//                the car one floor at a time, opens the door on arrival and
//                clears served requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_elevador #(
    parameter int unsigned TRAVEL_CYCLES = 50000000,
    parameter int unsigned DOOR_CYCLES   = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A0,
    input  logic       A1,
    input  logic       A2,
    output logic [1:0] andar,
    output logic       sobe,
    output logic       desce,
    output logic       porta,
    output logic [2:0] pendentes,
    output logic [2:0] servido
);

    // Counter holds at most (largest parameter - 1); never narrower than 27 bits.
    localparam int unsigned c_MAXP = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int          c_CW   = ($clog2(c_MAXP) > 27) ? $clog2(c_MAXP) : 27;

    localparam logic [c_CW-1:0] c_TRAVEL_LOAD = c_CW'(TRAVEL_CYCLES - 1);
    localparam logic [c_CW-1:0] c_DOOR_LOAD   = c_CW'(DOOR_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE     = c_CW'(1);

    localparam logic [1:0] c_PARADO   = 2'd0;
    localparam logic [1:0] c_SUBINDO  = 2'd1;
    localparam logic [1:0] c_DESCENDO = 2'd2;
    localparam logic [1:0] c_PORTA    = 2'd3;

    logic [1:0]      r_state, w_state_nxt;
    logic            r_dir, w_dir_nxt;          // 0 = up, 1 = down
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]      r_andar, w_andar_nxt;
    logic [2:0]      r_pend, w_pend_nxt;
    logic [2:0]      r_serv, w_serv_nxt;
    logic [2:0]      r_a_prev;

    logic [2:0]      w_a;
    logic [2:0]      w_edge;
    logic [2:0]      w_here;
    logic            w_above;
    logic            w_below;

    assign w_a    = {A2, A1, A0};
    assign w_edge = w_a & ~r_a_prev;
    assign w_here = 3'b001 << r_andar;

    // Pending requests strictly above / below the car; floor 3 does not exist.
    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        case (r_andar)
            2'd0: w_above = r_pend[1] | r_pend[2];
            2'd1: begin
                w_above = r_pend[2];
                w_below = r_pend[0];
            end
            2'd2: w_below = r_pend[0] | r_pend[1];
            default: begin
                w_above = 1'b0;
                w_below = 1'b0;
            end
        endcase
    end

    // Next-state, counter, position and request bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_andar_nxt = r_andar;
        w_pend_nxt  = r_pend | w_edge;
        w_serv_nxt  = 3'b000;
        case (r_state)
            c_PARADO: begin
                if (|(r_pend & w_here)) begin
                    // Serving the current floor: the clear beats a same-cycle edge.
                    w_state_nxt = c_PORTA;
                    w_pend_nxt  = (r_pend | w_edge) & ~w_here;
                    w_serv_nxt  = w_here;
                    w_cnt_nxt   = c_DOOR_LOAD;
                end else if (!r_dir && w_above) begin
                    w_state_nxt = c_SUBINDO;
                    w_cnt_nxt   = c_TRAVEL_LOAD;
                end else if (r_dir && w_below) begin
                    w_state_nxt = c_DESCENDO;
                    w_cnt_nxt   = c_TRAVEL_LOAD;
                end else if (w_above) begin
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = c_SUBINDO;
                    w_cnt_nxt   = c_TRAVEL_LOAD;
                end else if (w_below) begin
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = c_DESCENDO;
                    w_cnt_nxt   = c_TRAVEL_LOAD;
                end
            end
            c_SUBINDO: begin
                if (r_cnt == '0) begin
                    w_andar_nxt = r_andar + 2'd1;
                    w_state_nxt = c_PARADO;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_DESCENDO: begin
                if (r_cnt == '0) begin
                    w_andar_nxt = r_andar - 2'd1;
                    w_state_nxt = c_PARADO;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                // Door open: a new press at this floor keeps the door open
                // instead of queueing another request.
                w_pend_nxt = r_pend | (w_edge & ~w_here);
                if (|(w_edge & w_here)) begin
                    w_cnt_nxt = c_DOOR_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_PARADO;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_PARADO;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_andar  <= 2'd0;
            r_pend   <= 3'b000;
            r_serv   <= 3'b000;
            r_a_prev <= 3'b000;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_andar  <= w_andar_nxt;
            r_pend   <= w_pend_nxt;
            r_serv   <= w_serv_nxt;
            r_a_prev <= w_a;
        end
    end

    assign andar     = r_andar;
    assign sobe      = (r_state == c_SUBINDO);
    assign desce     = (r_state == c_DESCENDO);
    assign porta     = (r_state == c_PORTA);
    assign pendentes = r_pend;
    assign servido   = r_serv;

endmodule
`default_nettype wire

// File: tb/tb_controle_elevador.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_elevador
//  Description : Randomized self-checking bench for controle_elevador with a
//                behavioural model of the SCAN elevator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_elevador;

    localparam int c_T = 4;
    localparam int c_D = 3;

    logic       clk;
    logic       rst;
    logic       a0, a1, a2;
    logic [1:0] andar;
    logic       sobe, desce, porta;
    logic [2:0] pendentes, servido;

    int checks;
    int errors;

    controle_elevador #(
        .TRAVEL_CYCLES(c_T),
        .DOOR_CYCLES  (c_D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A0       (a0),
        .A1       (a1),
        .A2       (a2),
        .andar    (andar),
        .sobe     (sobe),
        .desce    (desce),
        .porta    (porta),
        .pendentes(pendentes),
        .servido  (servido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: floor number, per-floor request flags, activity
    // (idle/moving up/moving down/door) and elapsed cycles of that activity.
    int m_floor;
    bit m_pend[3];
    bit m_prev[3];
    bit m_serv[3];
    bit m_going_down;
    int m_act;          // 0 idle, 1 going up, 2 going down, 3 door open
    int m_elapsed;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit [2:0] a);
        bit e[3];
        bit above, below;
        for (int i = 0; i < 3; i++) begin
            e[i]      = a[i] && !m_prev[i];
            m_serv[i] = 1'b0;
        end
        if (r) begin
            m_floor = 0; m_going_down = 0; m_act = 0; m_elapsed = 0;
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 0; m_prev[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 3; i++) m_prev[i] = a[i];
        above = 0;
        below = 0;
        for (int i = 0; i < 3; i++) begin
            if (m_pend[i] && i > m_floor) above = 1;
            if (m_pend[i] && i < m_floor) below = 1;
        end
        if (m_act == 0) begin
            if (m_pend[m_floor]) begin
                m_act = 3; m_elapsed = 0;
                m_serv[m_floor] = 1;
                m_pend[m_floor] = 0;
                e[m_floor] = 0;
            end else if (!m_going_down && above) begin
                m_act = 1; m_elapsed = 0;
            end else if (m_going_down && below) begin
                m_act = 2; m_elapsed = 0;
            end else if (above) begin
                m_going_down = 0; m_act = 1; m_elapsed = 0;
            end else if (below) begin
                m_going_down = 1; m_act = 2; m_elapsed = 0;
            end
        end else if (m_act == 1 || m_act == 2) begin
            m_elapsed++;
            if (m_elapsed == c_T) begin
                m_floor = (m_act == 1) ? m_floor + 1 : m_floor - 1;
                m_act = 0;
            end
        end else begin
            if (e[m_floor]) begin
                m_elapsed = 0;
                e[m_floor] = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == c_D) m_act = 0;
            end
        end
        for (int i = 0; i < 3; i++) if (e[i]) m_pend[i] = 1;
    endtask

    // Apply one cycle of stimulus, advance the model on the edge, compare after it.
    task automatic cycle(input bit r, input bit [2:0] a);
        rst = r;
        {a2, a1, a0} = a;
        @(posedge clk);
        model_step(r, a);
        #1;
        chk("andar",     8'(andar),     8'(m_floor));
        chk("sobe",      8'(sobe),      8'(m_act == 1));
        chk("desce",     8'(desce),     8'(m_act == 2));
        chk("porta",     8'(porta),     8'(m_act == 3));
        chk("pendentes", 8'(pendentes), 8'({m_pend[2], m_pend[1], m_pend[0]}));
        chk("servido",   8'(servido),   8'({m_serv[2], m_serv[1], m_serv[0]}));
    endtask

    bit [2:0] cur_a;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        {a2, a1, a0} = 3'b000;
        cur_a = 3'b000;

        // Reset held two cycles, then twenty quiet cycles.
        cycle(1'b1, 3'b000);
        cycle(1'b1, 3'b000);
        repeat (20) cycle(1'b0, 3'b000);

        // Directed: local call, two-floor trip, SCAN with both ends pending.
        cycle(1'b0, 3'b001);
        repeat (8) cycle(1'b0, 3'b000);
        cycle(1'b0, 3'b100);
        repeat (8) cycle(1'b0, 3'b000);
        cycle(1'b0, 3'b101);
        repeat (30) cycle(1'b0, 3'b000);

        // Directed: go to floor 1, hold A1 high across the door, then release.
        cycle(1'b0, 3'b010);
        repeat (7) cycle(1'b0, 3'b000);
        repeat (12) cycle(1'b0, 3'b010);
        repeat (4) cycle(1'b0, 3'b000);

        // Directed: reset in the middle of a trip.
        cycle(1'b0, 3'b100);
        repeat (3) cycle(1'b0, 3'b000);
        cycle(1'b1, 3'b000);
        repeat (5) cycle(1'b0, 3'b000);

        // Randomized: sparse switch toggles and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 9) == 0) cur_a[i] = ~cur_a[i];
            cycle(($urandom_range(0, 299) == 0), cur_a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controle_elevador.md
# controle_elevador

Sequencing controller for the three-floor elevator. It takes the merged per-floor call lines (internal OR external switch, one line per floor), latches each new call as a pending request, and runs a directional (SCAN) state machine. The state machine moves the car between floors, opens the door on arrival and clears served requests. Its outputs drive the floor display, motor direction indicators and door indicator.

## Interface
- TRAVEL_CYCLES, default 50000000: clock cycles to move one floor (1 s at 50 MHz); legal values are 1 and up.
- DOOR_CYCLES, default 100000000: clock cycles the door stays open; legal values are 1 and up.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- A0, A1, A2  in  1 each  merged call line for floors 0/1/2; a level signal from switches.
- andar  out  2  current floor, 0..2. Value 3 is never produced.
- sobe  out  1  high while moving up (state SUBINDO).
- desce  out  1  high while moving down (state DESCENDO).
- porta  out  1  high while the door is open (state PORTA).
- pendentes  out  3  latched, not-yet-served requests; bit i is floor i.
- servido  out  3  one-cycle pulse: bit i is high in the cycle floor i's door opens.

## Operation
- **Call capture**
  - Each A[i] is registered into a_prev[i].
  - A rising edge is A[i]=1 and a_prev[i]=0. The edge sets pendentes[i].
  - A switch held high counts once; it must fall and rise again to re-request.
- **Internal state**
  - FSM states: PARADO, SUBINDO, DESCENDO, PORTA.
  - dir register: 0 = up, 1 = down.
  - One shared cycle counter, 27 bits minimum, or wide enough for the largest parameter.
- **PARADO decisions, first match wins:**
  1. pendentes[andar]=1 → go to PORTA. Clear that bit, pulse servido[andar], load counter.
  2. dir=up and a pending request exists above andar → SUBINDO.
  3. dir=down and a pending request exists below andar → DESCENDO.
  4. A pending request exists above → dir=up, SUBINDO.
  5. A pending request exists below → dir=down, DESCENDO.
  6. Otherwise stay in PARADO.
- **SUBINDO / DESCENDO**
  - The counter counts TRAVEL_CYCLES cycles.
  - On the last cycle: andar ±1, then return to PARADO.
  - The car always spends exactly one PARADO cycle at every floor it reaches, including pass-through floors. sobe and desce are low in that cycle.
- **PORTA**
  - The counter counts DOOR_CYCLES cycles, then returns to PARADO.
  - A rising edge on A[andar] during PORTA restarts the door counter. It does not set pendentes[andar].
  - Edges on the other floors latch normally.
- **Range guarantee:** the decision logic never moves up from floor 2 or down from floor 0.
- **Simultaneous events**
  - Entering PORTA at floor f while an edge arrives on A[f] in the same cycle: the clear wins. pendentes[f] stays 0.
  - Edges on several floors in one cycle: all are latched.
  - Edges arriving while moving: latched, and evaluated at the next PARADO cycle.

## Timing
- **Reset values:**
  - andar=0, sobe=0, desce=0, porta=0, pendentes=000, servido=000.
  - State PARADO, dir=up, counter=0, a_prev=000.
- **Reset mid-operation:** reset during any state returns all of the above on the next edge. The car position is reset to floor 0; no pending requests survive.
- **Call latency:** A[i] rising before edge k makes pendentes[i]=1 after edge k.
- **Call at the current floor while in PARADO:** porta=1 and servido pulse after edge k+1.
- **Door:** porta is high for exactly DOOR_CYCLES cycles, longer only if restarted.
- **One-floor trip:** sobe or desce is high for exactly TRAVEL_CYCLES cycles. andar updates on the same edge that drops sobe or desce.
- **End to end:** a call one floor away from an idle car opens the door after 1 + TRAVEL_CYCLES + 1 cycles from the latch.
- **Outputs:** all outputs are registered, with no combinational path from A* to any output.

## Test plan
All scenarios use TRAVEL_CYCLES=4 and DOOR_CYCLES=3.
- **Reset:** hold rst for 2 cycles, then release with all inputs low → all outputs 0, andar=0, and they stay so for 20 cycles.
- **Local call:** pulse A0 at floor 0 → pendentes=001 for 1 cycle; then servido=001 for 1 cycle and porta=1 for 3 cycles; then pendentes=000 and porta=0.
- **Two-floor trip:** A2 pulse at floor 0 → sobe=1 for 4 cycles, andar=1, one PARADO cycle, sobe=1 for 4 cycles, andar=2, servido=100, porta=1 for 3 cycles.
- **SCAN order:** car moving from floor 1 to floor 2, with A0 and A2 both latched → floor 2 is served first (andar=2, servido=100). Then desce runs for 8 cycles total to floor 0, which is served.
- **Held switch and door restart:**
  - Door open at floor 1, A1 rises and stays high → door counter restarts once; porta is high 3 cycles after the edge; pendentes[1] stays 0.
  - After the door closes, the still-high A1 causes no reopen.
- **Reset mid-travel:** assert rst in the middle of SUBINDO from floor 1 to floor 2, with pendentes=100 → after the edge: andar=0, sobe=0, pendentes=000, state PARADO.
